ir_key_event_queue: RTL and testbench
=====================================

IR_KEY_EVENT_QUEUE -- requirements
Module: ir_key_event_queue

Interface
REQ-001 SHALL have parameter HOLD_TIMEOUT, default 1000, cycles without a matching frame before a held key is released.
REQ-002 SHALL have parameter REPEAT_DELAY, default 400, cycles from press to first auto-repeat event.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 100, cycles between subsequent auto-repeat events.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: comando  in  8  decoded command byte from the IR decoder.
REQ-007 SHALL have ports: comparador  in  8  decoded inverted-command byte from the IR decoder.
REQ-008 SHALL have ports: frame_valid  in  1  one-cycle strobe; comando/comparador valid.
REQ-009 SHALL have ports: clr_stat  in  1  one-cycle strobe clearing err_count and overflow.
REQ-010 SHALL have ports: key_ready  in  1  consumer accepts head event.
REQ-011 SHALL have ports: key_valid  out  1  queue non-empty.
REQ-012 SHALL have ports: key_code  out  8  head event code.
REQ-013 SHALL have ports: key_repeat  out  1  head event is auto-repeat (0 = new press).
REQ-014 SHALL have ports: key_held  out  1  a key is currently held.
REQ-015 SHALL have ports: err_count  out  8  rejected-frame count, saturating at 255.
REQ-016 SHALL have ports: overflow  out  1  sticky; event dropped because queue full.

Function
REQ-017 SHALL accept a frame when frame_valid=1 and (comando XOR comparador) = 8'hFF; otherwise reject it and increment err_count (saturating at 255).
REQ-018 SHALL hold events in a 4-entry FIFO of {code[7:0], repeat}; pop occurs when key_valid=1 and key_ready=1.
REQ-019 SHALL, with the queue empty, assert key_valid the cycle after the push (1-cycle latency, no bypass).
REQ-020 SHALL implement states IDLE, HELD_DELAY, HELD_REPEAT.
REQ-021 SHALL, on an accepted frame in IDLE: push {comando,0}, latch held code, go to HELD_DELAY, clear hold and repeat timers.
REQ-022 SHALL, on an accepted frame in HELD_* with equal code: push nothing, clear hold timer only, and keep state.
REQ-023 SHALL, on an accepted frame in HELD_* with a different code: push {comando,0}, latch new code, go to HELD_DELAY, and clear both timers.
REQ-024 SHALL increment the hold timer each cycle in HELD_* and return to IDLE when it reaches HOLD_TIMEOUT with no frame that cycle; key_held=1 exactly in HELD_*.
REQ-025 SHALL, in HELD_DELAY, push {held code,1} when the repeat timer reaches REPEAT_DELAY, then enter HELD_REPEAT; in HELD_REPEAT, push {held code,1} every REPEAT_PERIOD cycles.
REQ-026 SHALL, when an accepted frame and a repeat tick coincide, push only the frame event (if any); the repeat timer restarts from 0 on a new press.
REQ-027 SHALL, when a hold timeout and a repeat tick coincide, go to IDLE without pushing.
REQ-028 SHALL, on a push while full with no simultaneous pop, drop the event and set overflow; on a push and a pop in the same cycle while full, accept both.
REQ-029 SHALL ignore a pop while empty; key_code/key_repeat are don't-care when key_valid=0.
REQ-030 SHALL, on clr_stat, zero err_count and overflow; a reject in the same cycle yields err_count=1.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, an empty queue, key_valid=0, key_code=0, key_repeat=0, key_held=0, err_count=0, overflow=0, and both timers 0, asynchronously.
REQ-032 SHALL discard queued events and any held key on reset mid-operation; the first frame after release is a new press.

Configuration
REQ-033 SHALL gate auto-repeat with macro IR_AUTO_REPEAT_EN: defined -> REQ-025 behaviour; undefined -> HELD_REPEAT and the repeat timer are absent, HELD_DELAY acts as a plain held state, and key_repeat is tied to 0.

Verification (HOLD_TIMEOUT=100, REPEAT_DELAY=40, REPEAT_PERIOD=20, macro defined unless noted)
REQ-034 SHALL cover: frame 8'h45/8'hBA, key_ready=1 -> key_valid=1 next cycle with key_code=8'h45, key_repeat=0, key_held=1.
REQ-035 SHALL cover: frame 8'h45/8'h45 -> no event, err_count=1; 300 bad frames -> err_count=255.
REQ-036 SHALL cover: single 8'h16 press, key_ready=1 -> repeats at +40, +60, +80 cycles; key_held falls at +100, with no further events.
REQ-037 SHALL cover: key_ready=0, presses 01, 02, 03, 04, 05 (valid complements) -> queue holds 01-04, overflow=1; 4 pops return 01..04 in order.
REQ-038 SHALL cover: 8'h0C held, then 8'h18 frame at +30 -> event {18,0}, first repeat of 18 at +70; macro undefined -> no repeat events ever, key_repeat=0.
REQ-039 SHALL cover: reset pulled low with 3 events queued and key held -> key_valid=0, key_held=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ir_key_event_queue.sv
// IR key event queue: validates decoded frames, tracks a held key with release timeout and
// optional auto-repeat (enabled by defining IR_AUTO_REPEAT_EN), buffering events in a 4-deep FIFO.
module ir_key_event_queue #(
  parameter int unsigned HOLD_TIMEOUT  = 1000,
  parameter int unsigned REPEAT_DELAY  = 400,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] comando,
  input  logic [7:0] comparador,
  input  logic       frame_valid,
  input  logic       clr_stat,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_repeat,
  output logic       key_held,
  output logic [7:0] err_count,
  output logic       overflow
);

  localparam int unsigned   HW       = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_TIMEOUT);

`ifdef IR_AUTO_REPEAT_EN
  localparam int unsigned   REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW         = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LIM  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_LIM = RW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HELD_DELAY = 2'd1
  } state_t;

  logic cfg_unused;
  assign cfg_unused = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

  logic          accept;
  logic          reject;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;
  logic          timeout;
  logic [7:0]    held_code_q, held_code_d;
  logic          push;
  logic [7:0]    push_code;

`ifdef IR_AUTO_REPEAT_EN
  logic [RW-1:0] rep_q, rep_d;
  logic [RW-1:0] rep_inc;
  logic [RW-1:0] rep_lim;
  logic          rep_tick;
  logic          push_rpt;
  logic [3:0]    rpt_q, rpt_d;
`endif

  logic [7:0]    code_q [4];
  logic [7:0]    code_d [4];
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    rd_q, rd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;

  logic [7:0]    err_q, err_d;
  logic          ovf_q, ovf_d;

  assign accept   = frame_valid & ((comando ^ comparador) == 8'hFF);
  assign reject   = frame_valid & ~accept;
  assign hold_inc = hold_q + HW'(1);
  assign timeout  = (hold_inc == HOLD_LIM);
  assign key_held = (state_q != IDLE);

`ifdef IR_AUTO_REPEAT_EN
  assign rep_inc  = rep_q + RW'(1);
  assign rep_lim  = (state_q == HELD_REPEAT) ? PERIOD_LIM : DELAY_LIM;
  assign rep_tick = (rep_inc == rep_lim);
`endif

  // Priority inside a held state: accepted frame, then hold timeout, then repeat tick.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    held_code_d = held_code_q;
    push        = 1'b0;
    push_code   = comando;
`ifdef IR_AUTO_REPEAT_EN
    push_rpt    = 1'b0;
    rep_d       = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          push        = 1'b1;
          held_code_d = comando;
          state_d     = HELD_DELAY;
          hold_d      = '0;
`ifdef IR_AUTO_REPEAT_EN
          rep_d       = '0;
`endif
        end
      end
      default: begin
        if (accept && (comando == held_code_q)) begin
          hold_d = '0;
`ifdef IR_AUTO_REPEAT_EN
          // A repeat tick suppressed by a refresh frame fires one cycle later: the timer is frozen.
          rep_d  = rep_tick ? rep_q : rep_inc;
`endif
        end else if (accept) begin
          push        = 1'b1;
          held_code_d = comando;
          state_d     = HELD_DELAY;
          hold_d      = '0;
`ifdef IR_AUTO_REPEAT_EN
          rep_d       = '0;
`endif
        end else if (timeout) begin
          state_d = IDLE;
          hold_d  = '0;
`ifdef IR_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          hold_d = hold_inc;
`ifdef IR_AUTO_REPEAT_EN
          if (rep_tick) begin
            push      = 1'b1;
            push_code = held_code_q;
            push_rpt  = 1'b1;
            state_d   = HELD_REPEAT;
            rep_d     = '0;
          end else begin
            rep_d = rep_inc;
          end
`endif
        end
      end
    endcase
  end

  assign key_valid = (cnt_q != 3'd0);
  assign pop       = key_valid & key_ready;
  assign full      = (cnt_q == 3'd4);
  assign do_push   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign key_code  = code_q[rd_q];
`ifdef IR_AUTO_REPEAT_EN
  assign key_repeat = rpt_q[rd_q];
`else
  assign key_repeat = 1'b0;
`endif

  always_comb begin
    code_d = code_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
`ifdef IR_AUTO_REPEAT_EN
    rpt_d  = rpt_q;
`endif
    if (do_push) begin
      code_d[wr_q] = push_code;
`ifdef IR_AUTO_REPEAT_EN
      rpt_d[wr_q]  = push_rpt;
`endif
      wr_d         = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d = rd_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b00, do_push} - {2'b00, pop};
  end

  // Clear is applied first so a same-cycle reject or drop is still recorded.
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr_stat) begin
      err_d = '0;
      ovf_d = 1'b0;
    end
    if (reject && (err_d != 8'hFF)) begin
      err_d = err_d + 8'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  assign err_count = err_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      held_code_q <= '0;
      code_q      <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
`ifdef IR_AUTO_REPEAT_EN
      rep_q       <= '0;
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      held_code_q <= held_code_d;
      code_q      <= code_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
`ifdef IR_AUTO_REPEAT_EN
      rep_q       <= rep_d;
      rpt_q       <= rpt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ir_key_event_queue.sv
// Testbench for ir_key_event_queue: vector table, directed corner sequences and random
// traffic against a deadline-based event model; adapts to IR_AUTO_REPEAT_EN.
module tb_ir_key_event_queue;

  localparam int HOLD   = 100;
  localparam int DELAY  = 40;
  localparam int PERIOD = 20;
`ifdef IR_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] comando = '0;
  logic [7:0] comparador = '0;
  logic       frame_valid = 1'b0;
  logic       clr_stat = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_repeat;
  logic       key_held;
  logic [7:0] err_count;
  logic       overflow;

  ir_key_event_queue #(
    .HOLD_TIMEOUT (HOLD),
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .comando    (comando),
    .comparador (comparador),
    .frame_valid(frame_valid),
    .clr_stat   (clr_stat),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_repeat (key_repeat),
    .key_held   (key_held),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] code;
    bit         rpt;
  } ev_t;

  // Reference model: event list plus absolute-cycle deadlines for release and repeat.
  ev_t        mq[$];
  bit         m_held;
  logic [7:0] m_code;
  int         m_seen;
  int         m_next;
  int         m_err;
  bit         m_ovf;
  int         cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    m_held = 1'b0;
    m_code = '0;
    m_seen = 0;
    m_next = 0;
    m_err  = 0;
    m_ovf  = 1'b0;
    cyc    = 0;
  endtask

  task automatic model_step();
    bit  acc, rej, pop_ok, have_push;
    ev_t pe;
    acc       = frame_valid && ((comando ^ comparador) == 8'hFF);
    rej       = frame_valid && !acc;
    pop_ok    = (mq.size() != 0) && key_ready;
    have_push = 1'b0;
    pe        = '{code: 8'h00, rpt: 1'b0};
    if (acc) begin
      if (!m_held || comando != m_code) begin
        have_push = 1'b1;
        pe        = '{code: comando, rpt: 1'b0};
        m_held    = 1'b1;
        m_code    = comando;
        m_seen    = cyc;
        m_next    = cyc + DELAY;
      end else begin
        m_seen = cyc;
        if (m_next == cyc) m_next = cyc + 1;
      end
    end else if (m_held && (cyc - m_seen == HOLD)) begin
      m_held = 1'b0;
    end else if (m_held && REP_EN && (cyc == m_next)) begin
      have_push = 1'b1;
      pe        = '{code: m_code, rpt: 1'b1};
      m_next    = cyc + PERIOD;
    end
    if (clr_stat) begin
      m_err = 0;
      m_ovf = 1'b0;
    end
    if (rej && m_err < 255) m_err++;
    if (pop_ok) void'(mq.pop_front());
    if (have_push) begin
      if (mq.size() < 4) mq.push_back(pe);
      else m_ovf = 1'b1;
    end
    cyc++;
  endtask

  task automatic model_check();
    chk("m_valid", key_valid, mq.size() != 0);
    chk("m_held", key_held, m_held);
    chk("m_err", err_count, m_err);
    chk("m_ovf", overflow, m_ovf);
    if (mq.size() != 0) begin
      chk("m_code", key_code, mq[0].code);
      chk("m_rpt", key_repeat, mq[0].rpt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    frame_valid = 1'b0;
    clr_stat    = 1'b0;
    key_ready   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_repeat", key_repeat, 1'b0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_err", err_count, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    model_clear();
    reset = 1'b1;
  endtask

  task automatic frame(input logic [7:0] c, input bit good);
    frame_valid = 1'b1;
    comando     = c;
    comparador  = good ? ~c : c;
  endtask

  typedef struct {
    bit         fv;
    logic [7:0] cmd;
    logic [7:0] cmp;
    bit         rdy;
    bit         clr;
    bit         ev;
    logic [7:0] ecode;
    bit         eheld;
    logic [7:0] eerr;
    bit         eovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int   reps[$];
    int   first_rep;
    logic [7:0] rep_code;
    int   pfr;

    tbl[0] = '{1'b1, 8'h45, 8'hBA, 1'b0, 1'b0, 1'b1, 8'h45, 1'b1, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 8'h45, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1'b1, 8'd1, 1'b0};
    tbl[2] = '{1'b1, 8'hA0, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0};
    tbl[3] = '{1'b1, 8'h12, 8'hED, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 8'd2, 1'b0};
    tbl[4] = '{1'b1, 8'h12, 8'hED, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0};
    tbl[7] = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'd0, 1'b0};
    tbl[8] = '{1'b1, 8'h33, 8'hCC, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'd0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      frame_valid = tbl[i].fv;
      comando     = tbl[i].cmd;
      comparador  = tbl[i].cmp;
      key_ready   = tbl[i].rdy;
      clr_stat    = tbl[i].clr;
      step();
      chk("tbl_valid", key_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_code", key_code, tbl[i].ecode);
        chk("tbl_repeat", key_repeat, 1'b0);
      end
      chk("tbl_held", key_held, tbl[i].eheld);
      chk("tbl_err", err_count, tbl[i].eerr);
      chk("tbl_ovf", overflow, tbl[i].eovf);
    end
    frame_valid = 1'b0;
    clr_stat    = 1'b0;

    // Error counter saturation.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      frame($urandom_range(255), 1'b0);
      step();
      if (k == 0) begin
        chk("bad_err1", err_count, 8'd1);
        chk("bad_noevent", key_valid, 1'b0);
      end
    end
    frame_valid = 1'b0;
    chk("bad_err_sat", err_count, 8'd255);

    // Single held press: repeat timing and release.
    do_reset();
    key_ready = 1'b1;
    reps.delete();
    for (int k = 0; k <= 130; k++) begin
      if (k == 0) frame(8'h16, 1'b1);
      else frame_valid = 1'b0;
      step();
      if (k == 0) begin
        chk("press_valid", key_valid, 1'b1);
        chk("press_code", key_code, 8'h16);
        chk("press_repeat", key_repeat, 1'b0);
        chk("press_held", key_held, 1'b1);
      end
      if (key_valid && key_repeat) reps.push_back(k);
      if (k == 99) chk("held_before_timeout", key_held, 1'b1);
      if (k == 100) chk("held_after_timeout", key_held, 1'b0);
    end
    chk("repeat_count", reps.size(), REP_EN ? 3 : 0);
    for (int i = 0; i < reps.size(); i++) chk("repeat_offset", reps[i], 40 + 20 * i);

    // Overflow with consumer stalled, then in-order drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frame(8'(i + 1), 1'b1);
      step();
    end
    frame_valid = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", key_valid, 1'b1);
      chk("drain_code", key_code, 8'(i + 1));
      step();
    end
    chk("drain_empty", key_valid, 1'b0);
    key_ready = 1'b0;

    // New key while held restarts the repeat delay.
    do_reset();
    key_ready = 1'b1;
    first_rep = -1;
    rep_code  = '0;
    for (int k = 0; k <= 80; k++) begin
      if (k == 0) frame(8'h0C, 1'b1);
      else if (k == 30) frame(8'h18, 1'b1);
      else frame_valid = 1'b0;
      step();
      if (k == 30) begin
        chk("switch_valid", key_valid, 1'b1);
        chk("switch_code", key_code, 8'h18);
        chk("switch_repeat", key_repeat, 1'b0);
      end
      if (key_valid && key_repeat && first_rep < 0) begin
        first_rep = k;
        rep_code  = key_code;
      end
    end
    chk("switch_first_rep", first_rep, REP_EN ? 70 : -1);
    chk("switch_rep_code", rep_code, REP_EN ? 8'h18 : 8'h00);

    // Asynchronous reset mid-operation.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame(8'h21 + 8'(i), 1'b1);
      step();
    end
    frame_valid = 1'b0;
    chk("pre_areset_held", key_held, 1'b1);
    reset = 1'b0;
    #1;
    chk("areset_valid", key_valid, 1'b0);
    chk("areset_held", key_held, 1'b0);
    chk("areset_code", key_code, 8'h00);
    do_reset();
    frame(8'h23, 1'b1);
    step();
    chk("post_reset_press_valid", key_valid, 1'b1);
    chk("post_reset_press_code", key_code, 8'h23);
    chk("post_reset_press_repeat", key_repeat, 1'b0);
    frame_valid = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0:       pfr = 4;
        1:       pfr = 12;
        2:       pfr = 60;
        default: pfr = 300;
      endcase
      for (int n = 0; n < 250; n++) begin
        frame_valid = ($urandom_range(pfr - 1) == 0);
        comando     = 8'(seg * 16) + 8'($urandom_range(2));
        comparador  = ($urandom_range(9) == 0) ? comando : ~comando;
        key_ready   = (seg % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
        clr_stat    = ($urandom_range(99) == 0);
        step();
      end
    end
    frame_valid = 1'b0;
    clr_stat    = 1'b0;
    key_ready   = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
